// File: rtl/rgy_phase_scheduler_if.sv
// Sensor/button inputs and lamp/status outputs of the two-road phase scheduler.
// The master drives requests and the slave drives the lamps.
interface rgy_phase_scheduler_if;
    logic       req0;
    logic       req1;
    logic       ped_req;
    logic [3:0] rgy0;
    logic [3:0] rgy1;
    logic [2:0] phase;
    logic       ped_pending;

    modport master (
        output req0, req1, ped_req,
        input  rgy0, rgy1, phase, ped_pending
    );

    modport slave (
        input  req0, req1, ped_req,
        output rgy0, rgy1, phase, ped_pending
    );
endinterface

// File: rtl/rgy_phase_scheduler.sv
// Two-road traffic-light phase scheduler with min/max green, yellow, all-red clearance
// and an inserted pedestrian WALK phase. Lamp outputs are registered Moore decodes of the state.
module rgy_phase_scheduler #(
    parameter int unsigned GREEN_MIN = 8,
    parameter int unsigned GREEN_MAX = 20,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned WALK_T    = 6,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    rgy_phase_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_AR   = 3'd0,
        ST_G0   = 3'd1,
        ST_Y0   = 3'd2,
        ST_G1   = 3'd3,
        ST_Y1   = 3'd4,
        ST_WALK = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_Y    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK_T - 1);

    localparam logic [3:0] LAMP_RED    = 4'b0001;
    localparam logic [3:0] LAMP_YELLOW = 4'b0010;
    localparam logic [3:0] LAMP_GREEN  = 4'b0100;
    localparam logic [3:0] LAMP_WALK   = 4'b1001;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q;
    logic             last_dir_q, last_dir_d;
    logic             ped_q, ped_d;
    logic [3:0]       rgy0_d, rgy1_d;
    logic             comp0, comp1;

    // Next state, bookkeeping and lamp decode of the next state
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        ped_d      = ped_q;
        rgy0_d     = LAMP_RED;
        rgy1_d     = LAMP_RED;
        comp0      = bus.req1 | ped_q;
        comp1      = bus.req0 | ped_q;

        if (bus.ped_req && (state_q != ST_WALK)) begin
            ped_d = 1'b1;
        end

        case (state_q)
            ST_AR: begin
                if (timer_q == T_AR) begin
                    if (ped_q) begin
                        state_d = ST_WALK;
                        ped_d   = 1'b0;   // clear beats a coincident button press
                    end else begin
                        state_d = last_dir_q ? ST_G0 : ST_G1;
                    end
                end
            end
            ST_G0: begin
                if (((timer_q >= T_GMIN) && comp0 && !bus.req0) ||
                    ((timer_q >= T_GMAX) && comp0)) begin
                    state_d = ST_Y0;
                end
            end
            ST_Y0: begin
                if (timer_q == T_Y) begin
                    state_d    = ST_AR;
                    last_dir_d = 1'b0;
                end
            end
            ST_G1: begin
                if (((timer_q >= T_GMIN) && comp1 && !bus.req1) ||
                    ((timer_q >= T_GMAX) && comp1)) begin
                    state_d = ST_Y1;
                end
            end
            ST_Y1: begin
                if (timer_q == T_Y) begin
                    state_d    = ST_AR;
                    last_dir_d = 1'b1;
                end
            end
            ST_WALK: begin
                if (timer_q == T_WALK) begin
                    state_d = last_dir_q ? ST_G0 : ST_G1;
                end
            end
            default: begin
                state_d = ST_AR;
            end
        endcase

        case (state_d)
            ST_G0:   rgy0_d = LAMP_GREEN;
            ST_Y0:   rgy0_d = LAMP_YELLOW;
            ST_G1:   rgy1_d = LAMP_GREEN;
            ST_Y1:   rgy1_d = LAMP_YELLOW;
            ST_WALK: begin
                rgy0_d = LAMP_WALK;
                rgy1_d = LAMP_WALK;
            end
            default: begin
                rgy0_d = LAMP_RED;
                rgy1_d = LAMP_RED;
            end
        endcase
    end

    // State, saturating phase timer and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_AR;
            timer_q         <= '0;
            last_dir_q      <= 1'b1;
            ped_q           <= 1'b0;
            bus.rgy0        <= LAMP_RED;
            bus.rgy1        <= LAMP_RED;
            bus.phase       <= 3'd0;
            bus.ped_pending <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            ped_q      <= ped_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + CNT_W'(1);
            end
            bus.rgy0        <= rgy0_d;
            bus.rgy1        <= rgy1_d;
            bus.phase       <= 3'(state_d);
            bus.ped_pending <= ped_d;
        end
    end

endmodule
